// File: rtl/approx_accum_16_pkg.sv
// approx_accum_16_pkg
// Shared constants and types for the approximate window accumulator:
//   DATA_W       width of product terms and window sums
//   ACC_LEN_DEF  default number of beats summed per window (one 3x3 kernel)
//   state_t      output-side state: ACCUM (no result held) / FULL (result held)
package approx_accum_16_pkg;

   localparam int DATA_W      = 16;
   localparam int ACC_LEN_DEF = 9;

   typedef enum logic {
      ACCUM = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage : approx_accum_16_pkg

// File: rtl/approx_accum_16_if.sv
// approx_accum_16_if
// Stream bundle between a producer/consumer (master) and the accumulator (slave).
//   clr        master->slave  synchronous abort of the partial window sum
//   in_valid   master->slave  in_data carries a product term
//   in_data    master->slave  unsigned product term
//   in_ready   slave->master  accumulator accepts in_data this cycle
//   out_valid  slave->master  out_data/out_ovf hold a finished window sum
//   out_ready  master->slave  consumer takes the output this cycle
//   out_data   slave->master  approximate window sum
//   out_ovf    slave->master  approximate carry-out seen during the window
interface approx_accum_16_if;
   import approx_accum_16_pkg::*;

   logic              clr;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_ovf;

   modport master (
      output clr, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  clr, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );

endinterface : approx_accum_16_if

// File: rtl/cla_16_3.sv
// cla_16_3
// Approximate 16-bit carry-lookahead adder. The carry into each bit is looked
// ahead over at most the three preceding bit positions only; any carry that
// would have to travel further is dropped. cin is only visible to bits 0..3.
//   a, b   input  16  operands
//   cin    input  1   carry into bit 0
//   sum    output 16  approximate sum
//   cout   output 1   approximate carry out of bit 15 (window over bits 13..15)
module cla_16_3 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] g;
   logic [15:0] p;
   logic [16:0] c;

   assign g = a & b;
   assign p = a ^ b;

   genvar gi;
   generate
      for (gi = 0; gi <= 16; gi++) begin : g_carry
         localparam int LO = (gi > 3) ? gi - 3 : 0;
         logic cbit;
         // Fold generate/propagate over the window [LO, gi-1]; the window is
         // only three bits deep so this collapses to a shallow lookahead term.
         always_comb begin
            cbit = (LO == 0) ? cin : 1'b0;
            for (int j = LO; j < gi; j++) begin
               cbit = g[j] | (p[j] & cbit);
            end
         end
         assign c[gi] = cbit;
      end
   endgenerate

   assign sum  = p ^ c[15:0];
   assign cout = c[16];

endmodule : cla_16_3

// File: rtl/approx_accum_16.sv
// approx_accum_16
// Sums ACC_LEN unsigned 16-bit product terms per window through the
// approximate adder cla_16_3 and presents each window sum with a sticky
// approximate carry-out flag. One result register; input is back-pressured
// while a result is held and not being taken.
//   clk     input   rising-edge clock
//   rst_n   input   asynchronous active-low reset
//   bus     slave   stream bundle (clr, in_*, out_*), see approx_accum_16_if
// Parameters:
//   ACC_LEN  beats per window (2..255)
//   CNT_W    width of the beat counter
module approx_accum_16
   import approx_accum_16_pkg::*;
#(
   parameter int ACC_LEN = ACC_LEN_DEF,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   approx_accum_16_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

   state_t            state_reg;
   logic [DATA_W-1:0] acc_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              ovf_acc_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              out_ovf_reg;

   logic [DATA_W-1:0] add_sum;
   logic              add_cout;
   logic              out_valid;
   logic              accept;
   logic              final_beat;

   assign out_valid  = (state_reg == FULL);
   assign bus.in_ready = !bus.clr && (!out_valid || bus.out_ready);
   assign accept     = bus.in_valid && bus.in_ready;
   assign final_beat = accept && (cnt_reg == LAST_CNT);

   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data_reg;
   assign bus.out_ovf   = out_ovf_reg;

   cla_16_3 u_add (
      .a    (acc_reg),
      .b    (bus.in_data),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ACCUM;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         ovf_acc_reg  <= 1'b0;
         out_data_reg <= '0;
         out_ovf_reg  <= 1'b0;
      end else begin
         // A final beat while FULL implies out_ready, so the held result is
         // replaced in place and out_valid never drops.
         case (state_reg)
            ACCUM:   if (final_beat) state_reg <= FULL;
            FULL:    if (bus.out_ready && !final_beat) state_reg <= ACCUM;
            default: state_reg <= ACCUM;
         endcase

         // clr holds in_ready low, so it never coincides with an accepted beat.
         if (bus.clr) begin
            acc_reg     <= '0;
            cnt_reg     <= '0;
            ovf_acc_reg <= 1'b0;
         end else if (accept) begin
            if (final_beat) begin
               out_data_reg <= add_sum;
               out_ovf_reg  <= ovf_acc_reg | add_cout;
               acc_reg      <= '0;
               cnt_reg      <= '0;
               ovf_acc_reg  <= 1'b0;
            end else begin
               acc_reg     <= add_sum;
               cnt_reg     <= cnt_reg + CNT_W'(1);
               ovf_acc_reg <= ovf_acc_reg | add_cout;
            end
         end
      end
   end

endmodule : approx_accum_16

// File: tb/tb_approx_accum_16.sv
// tb_approx_accum_16
// Drives two accumulators (ACC_LEN=9 and ACC_LEN=2) side by side and checks
// them every cycle against a behavioural model built on a bit-window
// approximate addition, plus directed checks of the documented vectors.
module tb_approx_accum_16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        clr_d  [2];
   logic        iv_d   [2];
   logic [15:0] id_d   [2];
   logic        ordy_d [2];

   logic        ir_o   [2];
   logic        ov_o   [2];
   logic [15:0] od_o   [2];
   logic        oovf_o [2];

   approx_accum_16_if bus9 ();
   approx_accum_16_if bus2 ();

   assign bus9.clr       = clr_d[0];
   assign bus9.in_valid  = iv_d[0];
   assign bus9.in_data   = id_d[0];
   assign bus9.out_ready = ordy_d[0];
   assign bus2.clr       = clr_d[1];
   assign bus2.in_valid  = iv_d[1];
   assign bus2.in_data   = id_d[1];
   assign bus2.out_ready = ordy_d[1];

   assign ir_o[0]   = bus9.in_ready;
   assign ov_o[0]   = bus9.out_valid;
   assign od_o[0]   = bus9.out_data;
   assign oovf_o[0] = bus9.out_ovf;
   assign ir_o[1]   = bus2.in_ready;
   assign ov_o[1]   = bus2.out_valid;
   assign od_o[1]   = bus2.out_data;
   assign oovf_o[1] = bus2.out_ovf;

   approx_accum_16 #(.ACC_LEN(9), .CNT_W(8)) dut9 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus9)
   );

   approx_accum_16 #(.ACC_LEN(2), .CNT_W(8)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          len_m [2] = '{9, 2};
   int          cnt_m [2];
   logic [15:0] sum_m [2];
   bit          ovf_m [2];
   bit          ev_m  [2];
   logic [15:0] ed_m  [2];
   bit          eo_m  [2];

   int n_checks = 0;
   int n_fail   = 0;
   int n_outs   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Approximate addition: bit i of the sum sees a carry only if it is
   // generated within the three bit positions just below i (cin = 0).
   function automatic logic [16:0] approx_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] r;
      int carry;
      r = '0;
      for (int i = 0; i <= 16; i++) begin
         int lo;
         lo = (i > 3) ? i - 3 : 0;
         carry = 0;
         // carry into bit i = carry out of the exact sum of bits [lo, i-1]
         for (int j = lo; j < i; j++) carry = (int'(a[j]) + int'(b[j]) + carry) / 2;
         if (i < 16) r[i] = 1'(int'(a[i]) + int'(b[i]) + carry);
         else        r[16] = 1'(carry);
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         cnt_m[d] = 0; sum_m[d] = '0; ovf_m[d] = 1'b0;
         ev_m[d] = 1'b0; ed_m[d] = '0; eo_m[d] = 1'b0;
      end
   endtask

   task automatic model_update(input int d);
      bit rdy, acc, fin;
      logic [16:0] r;
      rdy = !clr_d[d] && (!ev_m[d] || ordy_d[d]);
      acc = iv_d[d] && rdy;
      fin = acc && (cnt_m[d] == len_m[d] - 1);
      if (ev_m[d] && ordy_d[d]) n_outs++;
      if (clr_d[d]) begin
         cnt_m[d] = 0; sum_m[d] = '0; ovf_m[d] = 1'b0;
      end else if (acc) begin
         r = approx_add(sum_m[d], id_d[d]);
         if (fin) begin
            ed_m[d] = r[15:0]; eo_m[d] = ovf_m[d] | r[16];
            cnt_m[d] = 0; sum_m[d] = '0; ovf_m[d] = 1'b0;
         end else begin
            sum_m[d] = r[15:0]; cnt_m[d]++; ovf_m[d] = ovf_m[d] | r[16];
         end
      end
      if (fin) ev_m[d] = 1'b1;
      else if (ordy_d[d]) ev_m[d] = 1'b0;
   endtask

   // One clock: compare on the falling edge, advance the model, return 1ns
   // after the rising edge so the caller can drive the next inputs.
   task automatic step();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("in_ready[%0d]", d), 32'(ir_o[d]),
               32'(!clr_d[d] && (!ev_m[d] || ordy_d[d])));
         check($sformatf("out_valid[%0d]", d), 32'(ov_o[d]), 32'(ev_m[d]));
         if (ev_m[d]) begin
            check($sformatf("out_data[%0d]", d), 32'(od_o[d]), 32'(ed_m[d]));
            check($sformatf("out_ovf[%0d]", d), 32'(oovf_o[d]), 32'(eo_m[d]));
         end
      end
      if (!rst_n) model_reset();
      else for (int d = 0; d < 2; d++) model_update(d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         clr_d[d] = 1'b0; iv_d[d] = 1'b0; id_d[d] = '0; ordy_d[d] = 1'b1;
      end
   endtask

   task automatic beat(input int d, input logic [15:0] data);
      iv_d[d] = 1'b1; id_d[d] = data;
      step();
      iv_d[d] = 1'b0;
   endtask

   initial begin
      idle_all();
      model_reset();

      // reset state; in_ready follows !clr while held in reset
      step(); step();
      clr_d[0] = 1'b1;
      step();
      clr_d[0] = 1'b0;
      check("rst_out_data", 32'(od_o[0]), 32'h0);
      check("rst_out_ovf", 32'(oovf_o[1]), 32'h0);
      rst_n = 1'b1;
      step();

      // nine beats of 1 -> 0x0009, out_valid for exactly one cycle
      for (int k = 0; k < 9; k++) beat(0, 16'h0001);
      check("w9_data", 32'(od_o[0]), 32'h0009);
      check("w9_ovf", 32'(oovf_o[0]), 32'h0);
      check("w9_valid", 32'(ov_o[0]), 32'h1);
      step();
      check("w9_valid_drop", 32'(ov_o[0]), 32'h0);

      // 0x000F + 0x0001 -> carry beyond the window is lost
      beat(1, 16'h000F); beat(1, 16'h0001);
      check("trunc_data", 32'(od_o[1]), 32'h0000);
      check("trunc_ovf", 32'(oovf_o[1]), 32'h0);
      step();

      // carry-out on the final beat, then a clean window
      beat(1, 16'hFFFF); beat(1, 16'h8000);
      check("cout_data", 32'(od_o[1]), 32'h7FFF);
      check("cout_ovf", 32'(oovf_o[1]), 32'h1);
      beat(1, 16'h0001); beat(1, 16'h0001);
      check("after_cout_data", 32'(od_o[1]), 32'h0002);
      check("after_cout_ovf", 32'(oovf_o[1]), 32'h0);
      step();

      // back-pressure: result held, input refused for five cycles
      ordy_d[1] = 1'b0;
      beat(1, 16'h0005); beat(1, 16'h0006);
      iv_d[1] = 1'b1; id_d[1] = 16'h0007;
      for (int k = 0; k < 5; k++) begin
         step();
         check("stall_data", 32'(od_o[1]), 32'h000B);
         check("stall_ready", 32'(ir_o[1]), 32'h0);
      end
      ordy_d[1] = 1'b1;
      beat(1, 16'h0007); beat(1, 16'h0008);
      check("resume_data", 32'(od_o[1]), 32'h000F);
      check("resume_valid", 32'(ov_o[1]), 32'h1);
      step();

      // clr after four beats, with a pending result on the other instance
      ordy_d[1] = 1'b0;
      beat(1, 16'h0011); beat(1, 16'h0022);
      for (int k = 0; k < 4; k++) beat(0, 16'h0003);
      clr_d[0] = 1'b1; clr_d[1] = 1'b1;
      step();
      clr_d[0] = 1'b0; clr_d[1] = 1'b0;
      check("clr_keeps_valid", 32'(ov_o[1]), 32'h1);
      check("clr_keeps_data", 32'(od_o[1]), 32'h0033);
      for (int k = 0; k < 9; k++) beat(0, 16'h0002);
      check("clr_then_data", 32'(od_o[0]), 32'h0012);
      step();

      // asynchronous reset pulse after four beats
      for (int k = 0; k < 4; k++) beat(0, 16'h0003);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(ov_o[1]), 32'h0);
      check("async_rst_data", 32'(od_o[1]), 32'h0);
      check("async_rst_ready", 32'(ir_o[0]), 32'h1);
      model_reset();
      step();
      rst_n = 1'b1;
      ordy_d[1] = 1'b1;
      for (int k = 0; k < 9; k++) beat(0, 16'h0002);
      check("rst_then_data", 32'(od_o[0]), 32'h0012);
      check("rst_then_ovf", 32'(oovf_o[0]), 32'h0);
      step();

      // randomized traffic on both instances
      for (int n = 0; n < 4000; n++) begin
         for (int d = 0; d < 2; d++) begin
            clr_d[d]  = ($urandom_range(0, 31) == 0);
            iv_d[d]   = ($urandom_range(0, 3) != 0);
            id_d[d]   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            ordy_d[d] = ($urandom_range(0, 3) != 0);
         end
         step();
      end
      idle_all();
      step();
      check("outputs_seen", 32'(n_outs > 200), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_approx_accum_16

// File: doc/approx_accum_16.md
APPROX_ACCUM_16 -- requirements
Module: approx_accum_16

Interface
REQ-001 SHALL have parameter ACC_LEN, default 9, number of input beats summed per output (one 3x3 kernel window); legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 8, width of the beat counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 clr  input  1  synchronous abort; discards the partial sum.
REQ-007 in_valid  input  1  in_data carries a product term.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  16  unsigned product term.
REQ-010 out_valid  output  1  out_data/out_ovf hold a finished window sum.
REQ-011 out_ready  input  1  consumer takes the output this cycle.
REQ-012 out_data  output  16  approximate window sum.
REQ-013 out_ovf  output  1  approximate carry-out seen during the window.

Function
REQ-014 SHALL form every sum as acc + in_data through one approximate 16-bit CLA instance with cin=0; no exact adder.
REQ-015 Beat accepted SHALL mean in_valid && in_ready at a rising clk edge.
REQ-016 in_ready SHALL equal !clr && (!out_valid || out_ready), combinationally.
REQ-017 On a non-final accepted beat: acc <= adder sum; cnt <= cnt+1; ovf_acc <= ovf_acc | cout.
REQ-018 Final beat is the beat accepted with cnt == ACC_LEN-1.
REQ-019 On the final beat: out_data <= adder sum; out_ovf <= ovf_acc | cout; out_valid <= 1; acc, cnt, ovf_acc <= 0.
REQ-020 Latency: out_valid SHALL rise one cycle after the final beat is accepted.
REQ-021 While out_valid && !out_ready, out_data and out_ovf SHALL stay stable and no beat SHALL be accepted.
REQ-022 out_ready without a final beat in the same cycle SHALL clear out_valid at the next edge.
REQ-023 A final beat in the same cycle as out_ready SHALL reload the output; out_valid stays 1 with no bubble.
REQ-024 clr SHALL zero acc, cnt, ovf_acc next cycle and SHALL force in_ready low; a pending output is unaffected.
REQ-025 A cout on the final beat SHALL reach out_ovf for that window only.
REQ-026 State is ACCUM when out_valid=0 and FULL when out_valid=1.
REQ-027 ACCUM->FULL on the final beat; FULL->ACCUM on out_ready without a final beat; FULL->FULL on both.

Reset
REQ-028 rst_n low SHALL asynchronously force acc=0, cnt=0, ovf_acc=0, out_data=0, out_ovf=0, out_valid=0.
REQ-029 in_ready SHALL read 1 during reset unless clr is high.
REQ-030 Reset asserted mid-window SHALL discard the partial sum; the first beat after release starts a new window.

Structure
REQ-031 The shared package SHALL hold the ACC_LEN default, the data width (16), and the ACCUM/FULL state encoding.
REQ-032 The only sub-module SHALL be the existing approximate 16-bit CLA (cla_16_3); the counter and registers stay inline.

Verification
REQ-033 ACC_LEN=9, nine beats of 0x0001, out_ready=1 -> out_data=0x0009, out_ovf=0, out_valid high exactly 1 cycle.
REQ-034 ACC_LEN=2, beats 0x000F then 0x0001 -> out_data=0x0000 (approximate carry chain truncated), out_ovf=0.
REQ-035 ACC_LEN=2, beats 0xFFFF then 0x8000 -> out_data=0x7FFF, out_ovf=1; the next window of 0x0001, 0x0001 -> 0x0002, out_ovf=0.
REQ-036 Hold out_ready=0 for 5 cycles after a window completes -> out_data stable and in_ready=0; raise out_ready with the next window's final beat -> back-to-back outputs.
REQ-037 clr after 4 of 9 beats, or rst_n pulse after 4 of 9 beats, then nine beats of 0x0002 -> out_data=0x0012.
